pong_score_ctrl: RTL and testbench

- Game-state and scoring controller; consumes the ball block's p1_win/p2_win point pulses and decides when the ball runs, when it is re-served and when the match ends.
- Sits between the ball block and the board display: drives ball enable and serve, keeps both scores and flags game over.
- All outputs registered; single clock domain.

---
 rtl/pong_score_ctrl_if.sv | 34 +++
 rtl/pong_score_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pong_score_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pong_score_ctrl_if.sv
// Bundles the ball-block and board-display signals of the pong score controller.
// With SCORE_SEG_EN defined, the interface also carries the 7-segment score digits.
interface pong_score_ctrl_if;
  logic       start;
  logic       p1_win;
  logic       p2_win;
  logic       ball_en;
  logic       ball_serve;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       game_over;
  logic [1:0] winner;
`ifdef SCORE_SEG_EN
  logic [6:0] seg_p1;
  logic [6:0] seg_p2;
`endif

  modport master (
`ifdef SCORE_SEG_EN
    input  seg_p1, seg_p2,
`endif
    output start, p1_win, p2_win,
    input  ball_en, ball_serve, serve_dir, p1_score, p2_score, game_over, winner
  );

  modport slave (
`ifdef SCORE_SEG_EN
    output seg_p1, seg_p2,
`endif
    input  start, p1_win, p2_win,
    output ball_en, ball_serve, serve_dir, p1_score, p2_score, game_over, winner
  );
endinterface

// File: rtl/pong_score_ctrl.sv
// Pong game-state/scoring FSM: gates the ball, times serves, keeps scores, flags the winner.
// Optional macro SCORE_SEG_EN adds registered active-low 7-segment score decoders.
module pong_score_ctrl #(
  parameter logic [3:0]  WIN_SCORE   = 4'd5,
  parameter logic [25:0] SERVE_DELAY = 26'd50_000_000
) (
  input logic             clk,
  input logic             d_rst,
  pong_score_ctrl_if.slave bus
);

  localparam logic [25:0] SERVE_LAST = SERVE_DELAY - 26'd1;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t      state, state_nx;
  logic        start_q, p1_q, p2_q;
  logic        start_ev, p1_ev, p2_ev;
  logic [25:0] cnt, cnt_nx;
  logic [3:0]  p1_r, p2_r, p1_nx, p2_nx, p1_inc, p2_inc;
  logic        dir_r, dir_nx;
  logic [1:0]  win_r, win_nx;
  logic        en_r, serve_r, over_r;
  logic        en_nx, serve_nx, over_nx;

  assign start_ev = bus.start  & ~start_q;
  assign p1_ev    = bus.p1_win & ~p1_q;
  assign p2_ev    = bus.p2_win & ~p2_q;
  assign p1_inc   = p1_r + 4'd1;
  assign p2_inc   = p2_r + 4'd1;

  // Edge registers always track their inputs so levels held across ignored states never fire late.
  always_ff @(posedge clk or posedge d_rst) begin
    if (d_rst) begin
      start_q <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      start_q <= bus.start;
      p1_q    <= bus.p1_win;
      p2_q    <= bus.p2_win;
    end
  end

  always_ff @(posedge clk or posedge d_rst) begin
    if (d_rst) begin
      state   <= IDLE;
      cnt     <= 26'd0;
      p1_r    <= 4'd0;
      p2_r    <= 4'd0;
      dir_r   <= 1'b0;
      win_r   <= 2'b00;
      en_r    <= 1'b0;
      serve_r <= 1'b0;
      over_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      p1_r    <= p1_nx;
      p2_r    <= p2_nx;
      dir_r   <= dir_nx;
      win_r   <= win_nx;
      en_r    <= en_nx;
      serve_r <= serve_nx;
      over_r  <= over_nx;
    end
  end

  always_comb begin
    state_nx = state;
    p1_nx    = p1_r;
    p2_nx    = p2_r;
    dir_nx   = dir_r;
    win_nx   = win_r;
    case (state)
      IDLE: begin
        if (start_ev) begin
          state_nx = SERVE;
          p1_nx    = 4'd0;
          p2_nx    = 4'd0;
          dir_nx   = 1'b0;
        end
      end
      SERVE: begin
        if (cnt == SERVE_LAST) state_nx = PLAY;
      end
      PLAY: begin
        // p1 has priority on a simultaneous point; the p2 event is dropped.
        if (p1_ev) begin
          p1_nx = p1_inc;
          if (p1_inc == WIN_SCORE) begin
            state_nx = OVER;
            win_nx   = 2'b01;
          end else begin
            state_nx = SERVE;
            dir_nx   = 1'b0;
          end
        end else if (p2_ev) begin
          p2_nx = p2_inc;
          if (p2_inc == WIN_SCORE) begin
            state_nx = OVER;
            win_nx   = 2'b10;
          end else begin
            state_nx = SERVE;
            dir_nx   = 1'b1;
          end
        end
      end
      OVER: begin
        if (start_ev) begin
          state_nx = SERVE;
          p1_nx    = 4'd0;
          p2_nx    = 4'd0;
          win_nx   = 2'b00;
          dir_nx   = 1'b0;
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx == SERVE) cnt_nx = (state == SERVE) ? cnt + 26'd1 : 26'd0;
    serve_nx = (state_nx == SERVE) && (cnt_nx == SERVE_LAST);
    en_nx    = (state_nx == PLAY);
    over_nx  = (state_nx == OVER);
  end

  assign bus.ball_en    = en_r;
  assign bus.ball_serve = serve_r;
  assign bus.serve_dir  = dir_r;
  assign bus.p1_score   = p1_r;
  assign bus.p2_score   = p2_r;
  assign bus.game_over  = over_r;
  assign bus.winner     = win_r;

`ifdef SCORE_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [6:0] seg_p1_r, seg_p2_r;

  always_ff @(posedge clk or posedge d_rst) begin
    if (d_rst) begin
      seg_p1_r <= 7'b1000000;
      seg_p2_r <= 7'b1000000;
    end else begin
      seg_p1_r <= seg7(p1_r);
      seg_p2_r <= seg7(p2_r);
    end
  end

  assign bus.seg_p1 = seg_p1_r;
  assign bus.seg_p2 = seg_p2_r;
`endif

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed bench for pong_score_ctrl with WIN_SCORE=3, SERVE_DELAY=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pong_score_ctrl;
  logic clk = 1'b0;
  logic d_rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_p1 = 0;
  logic [6:0] seg_tab [0:9];

  pong_score_ctrl_if bus();

  pong_score_ctrl #(.WIN_SCORE(4'd3), .SERVE_DELAY(26'd4)) dut (
    .clk  (clk),
    .d_rst(d_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the cycle SERVE is entered; leaves the bench in the first PLAY cycle.
  task automatic serve_seq(input string tag);
    chk({tag, "_entry_en"}, 32'(bus.ball_en), 32'd0);
    chk({tag, "_entry_srv"}, 32'(bus.ball_serve), 32'd0);
    step();
    chk({tag, "_c1_srv"}, 32'(bus.ball_serve), 32'd0);
`ifdef SCORE_SEG_EN
    chk({tag, "_seg_p1"}, 32'(bus.seg_p1), 32'(seg_tab[exp_p1]));
`endif
    step();
    chk({tag, "_c2_srv"}, 32'(bus.ball_serve), 32'd0);
    step();
    chk({tag, "_c3_srv"}, 32'(bus.ball_serve), 32'd1);
    chk({tag, "_c3_en"}, 32'(bus.ball_en), 32'd0);
    step();
    chk({tag, "_c4_en"}, 32'(bus.ball_en), 32'd1);
    chk({tag, "_c4_srv"}, 32'(bus.ball_serve), 32'd0);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    d_rst = 1'b1;
    bus.start = 1'b0; bus.p1_win = 1'b0; bus.p2_win = 1'b0;
    repeat (3) step();
    chk("rst_en", 32'(bus.ball_en), 32'd0);
    chk("rst_srv", 32'(bus.ball_serve), 32'd0);
    chk("rst_dir", 32'(bus.serve_dir), 32'd0);
    chk("rst_p1", 32'(bus.p1_score), 32'd0);
    chk("rst_p2", 32'(bus.p2_score), 32'd0);
    chk("rst_over", 32'(bus.game_over), 32'd0);
    chk("rst_win", 32'(bus.winner), 32'd0);
`ifdef SCORE_SEG_EN
    chk("rst_seg_p1", 32'(bus.seg_p1), 32'h40);
`endif
    d_rst = 1'b0;
    repeat (5) step();

    // Point pulse while idle is ignored.
    bus.p1_win = 1'b1; step(); bus.p1_win = 1'b0; step();
    chk("idle_p1", 32'(bus.p1_score), 32'd0);
    chk("idle_en", 32'(bus.ball_en), 32'd0);

    // First serve.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("srv1_dir", 32'(bus.serve_dir), 32'd0);
    exp_p1 = 0;
    serve_seq("srv1");

    // p1_win held 20 cycles scores once.
    bus.p1_win = 1'b1; step();
    chk("hold_p1", 32'(bus.p1_score), 32'd1);
    chk("hold_dir", 32'(bus.serve_dir), 32'd0);
    exp_p1 = 1;
    serve_seq("hold_srv");
    repeat (15) step();
    chk("hold_p1_still", 32'(bus.p1_score), 32'd1);
    chk("hold_en", 32'(bus.ball_en), 32'd1);
    bus.p1_win = 1'b0; step();

    // Simultaneous points: p1 credited only.
    bus.p1_win = 1'b1; bus.p2_win = 1'b1; step();
    bus.p1_win = 1'b0; bus.p2_win = 1'b0;
    chk("sim_p1", 32'(bus.p1_score), 32'd2);
    chk("sim_p2", 32'(bus.p2_score), 32'd0);
    chk("sim_dir", 32'(bus.serve_dir), 32'd0);
`ifdef SCORE_SEG_EN
    chk("sim_seg_old", 32'(bus.seg_p1), 32'(seg_tab[1]));
`endif
    exp_p1 = 2;
    serve_seq("sim_srv");

    // Start in PLAY has no effect.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (3) step();
    chk("play_start_en", 32'(bus.ball_en), 32'd1);
    chk("play_start_srv", 32'(bus.ball_serve), 32'd0);
    chk("play_start_p1", 32'(bus.p1_score), 32'd2);

    // p2 wins the match with three points.
    for (int i = 1; i <= 3; i++) begin
      bus.p2_win = 1'b1; step(); bus.p2_win = 1'b0;
      chk("p2_pt", 32'(bus.p2_score), 32'(i));
      if (i < 3) begin
        chk("p2_dir", 32'(bus.serve_dir), 32'd1);
        serve_seq("p2_srv");
      end else begin
        chk("over_flag", 32'(bus.game_over), 32'd1);
        chk("over_win", 32'(bus.winner), 32'd2);
        chk("over_en", 32'(bus.ball_en), 32'd0);
        chk("over_srv", 32'(bus.ball_serve), 32'd0);
      end
    end

    // Points in OVER are ignored.
    bus.p1_win = 1'b1; bus.p2_win = 1'b1; step();
    bus.p1_win = 1'b0; bus.p2_win = 1'b0; step();
    bus.p1_win = 1'b1; step(); bus.p1_win = 1'b0;
    repeat (3) step();
    chk("over_p1", 32'(bus.p1_score), 32'd2);
    chk("over_p2", 32'(bus.p2_score), 32'd3);
    chk("over_hold", 32'(bus.game_over), 32'd1);
    chk("over_en2", 32'(bus.ball_en), 32'd0);
`ifdef SCORE_SEG_EN
    chk("over_seg_p2", 32'(bus.seg_p2), 32'(seg_tab[3]));
`endif

    // Restart from OVER.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("rs_p1", 32'(bus.p1_score), 32'd0);
    chk("rs_p2", 32'(bus.p2_score), 32'd0);
    chk("rs_over", 32'(bus.game_over), 32'd0);
    chk("rs_win", 32'(bus.winner), 32'd0);
    chk("rs_dir", 32'(bus.serve_dir), 32'd0);
    exp_p1 = 0;
    serve_seq("rs_srv");

    // Reset asserted mid-serve at counter=2.
    bus.p1_win = 1'b1; step(); bus.p1_win = 1'b0;
    chk("mid_p1", 32'(bus.p1_score), 32'd1);
    step(); step();
    d_rst = 1'b1; #1;
    chk("mid_rst_en", 32'(bus.ball_en), 32'd0);
    chk("mid_rst_srv", 32'(bus.ball_serve), 32'd0);
    chk("mid_rst_p1", 32'(bus.p1_score), 32'd0);
    chk("mid_rst_dir", 32'(bus.serve_dir), 32'd0);
`ifdef SCORE_SEG_EN
    chk("mid_rst_seg", 32'(bus.seg_p1), 32'h40);
`endif
    step();
    chk("mid_rst_srv2", 32'(bus.ball_serve), 32'd0);
    step();
    d_rst = 1'b0;
    repeat (6) step();
    chk("post_rst_en", 32'(bus.ball_en), 32'd0);
    chk("post_rst_srv", 32'(bus.ball_serve), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
